// File: rtl/fxp_dot_accum_if.sv
// Stream bundle for fxp_dot_accum: operand-pair input side and dot-product result side.
interface fxp_dot_accum_if #(
    parameter int NIN  = 8,
    parameter int NACC = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [NIN-1:0]  in_a;
    logic signed [NIN-1:0]  in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [NACC-1:0] out_acc;
    logic                   out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/fxp_dot_accum.sv
// Saturating fixed-point dot-product accumulator: LEN signed NIN-bit products summed
// into a NACC-bit result, presented with a sticky overflow flag on a valid/ready port.
module fxp_dot_accum #(
    parameter int NIN  = 8,
    parameter int NACC = 32,
    parameter int LEN  = 16
) (
    input logic             clk,
    input logic             rst,
    fxp_dot_accum_if.slave  bus
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic signed [NACC:0] ACC_MAX = {2'b00, {(NACC-1){1'b1}}};
    localparam logic signed [NACC:0] ACC_MIN = {2'b11, {(NACC-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                 state;
    logic signed [NACC-1:0] acc;
    logic                   ovf;
    logic [CW-1:0]          cnt;
    logic                   rdy;
    logic                   vld;
    logic signed [NACC-1:0] res_acc;
    logic                   res_ovf;

    logic signed [2*NIN-1:0] prod;
    logic signed [NACC:0]    sum;
    logic signed [NACC-1:0]  sum_sat;
    logic                    hit;
    logic                    take;

    function automatic logic signed [NACC-1:0] sat(input logic signed [NACC:0] s);
        if (s > ACC_MAX) return ACC_MAX[NACC-1:0];
        if (s < ACC_MIN) return ACC_MIN[NACC-1:0];
        return s[NACC-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [NACC:0] s);
        return (s > ACC_MAX) || (s < ACC_MIN);
    endfunction

    // One extra guard bit on the sum so a single step past either rail is still visible.
    assign prod    = bus.in_a * bus.in_b;
    assign sum     = (NACC+1)'(prod) + (NACC+1)'(acc);
    assign sum_sat = sat(sum);
    assign hit     = sat_hit(sum);
    assign take    = bus.in_valid && rdy && (state == ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            rdy     <= 1'b0;
            vld     <= 1'b0;
            res_acc <= '0;
            res_ovf <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    rdy <= 1'b1;
                    if (take) begin
                        acc <= sum_sat;
                        ovf <= ovf | hit;
                        if (cnt == CW'(LEN - 1)) begin
                            res_acc <= sum_sat;
                            res_ovf <= ovf | hit;
                            cnt     <= '0;
                            state   <= HOLD;
                            rdy     <= 1'b0;
                            vld     <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_acc   = res_acc;
    assign bus.out_ovf   = res_ovf;
endmodule

// File: tb/tb_fxp_dot_accum.sv
// Bench for fxp_dot_accum: three configurations driven from shared stimulus, each
// compared every cycle against a plain-arithmetic model, plus literal pins.
module tb_fxp_dot_accum;
    localparam int ND = 3;
    localparam int NACC_T [ND] = '{32, 16, 32};
    localparam int LEN_T  [ND] = '{4, 4, 1};

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic signed [7:0] in_a;
    logic signed [7:0] in_b;

    always #5 clk = ~clk;

    fxp_dot_accum_if #(.NIN(8), .NACC(32)) if0 ();
    fxp_dot_accum_if #(.NIN(8), .NACC(16)) if1 ();
    fxp_dot_accum_if #(.NIN(8), .NACC(32)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.in_a = in_a;  assign if0.in_b = in_b;  assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_a = in_a;  assign if1.in_b = in_b;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_a = in_a;  assign if2.in_b = in_b;  assign if2.out_ready = out_ready;

    fxp_dot_accum #(.NIN(8), .NACC(32), .LEN(4)) u_d0 (.clk(clk), .rst(rst), .bus(if0.slave));
    fxp_dot_accum #(.NIN(8), .NACC(16), .LEN(4)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
    fxp_dot_accum #(.NIN(8), .NACC(32), .LEN(1)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));

    longint act_acc [ND];
    logic   act_ovf [ND];
    logic   act_rdy [ND];
    logic   act_vld [ND];

    always_comb begin
        act_acc[0] = longint'(if0.out_acc); act_ovf[0] = if0.out_ovf; act_rdy[0] = if0.in_ready; act_vld[0] = if0.out_valid;
        act_acc[1] = longint'(if1.out_acc); act_ovf[1] = if1.out_ovf; act_rdy[1] = if1.in_ready; act_vld[1] = if1.out_valid;
        act_acc[2] = longint'(if2.out_acc); act_ovf[2] = if2.out_ovf; act_rdy[2] = if2.in_ready; act_vld[2] = if2.out_valid;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: running sum clamped to the NACC range after every accepted product.
    longint m_acc  [ND] = '{0, 0, 0};
    bit     m_ovf  [ND] = '{0, 0, 0};
    int     m_cnt  [ND] = '{0, 0, 0};
    bit     m_hold [ND] = '{0, 0, 0};
    bit     m_rdy  [ND] = '{0, 0, 0};
    bit     m_vld  [ND] = '{0, 0, 0};
    longint m_oacc [ND] = '{0, 0, 0};
    bit     m_oovf [ND] = '{0, 0, 0};
    bit     m_after_rst = 1'b0;

    always @(posedge clk) begin
        longint s, hi, lo;
        for (int k = 0; k < ND; k++) begin
            if (rst) begin
                m_acc[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
                m_rdy[k] = 0; m_vld[k] = 0; m_oacc[k] = 0; m_oovf[k] = 0;
            end else if (!m_hold[k]) begin
                if (in_valid && m_rdy[k]) begin
                    hi = (longint'(1) << (NACC_T[k] - 1)) - 1;
                    lo = -(longint'(1) << (NACC_T[k] - 1));
                    s  = m_acc[k] + longint'(in_a) * longint'(in_b);
                    if (s > hi) begin s = hi; m_ovf[k] = 1; end
                    if (s < lo) begin s = lo; m_ovf[k] = 1; end
                    m_acc[k] = s;
                    m_cnt[k]++;
                    if (m_cnt[k] == LEN_T[k]) begin
                        m_oacc[k] = m_acc[k]; m_oovf[k] = m_ovf[k];
                        m_cnt[k] = 0; m_hold[k] = 1; m_rdy[k] = 0; m_vld[k] = 1;
                    end else begin
                        m_rdy[k] = 1;
                    end
                end else begin
                    m_rdy[k] = 1;
                end
            end else if (out_ready) begin
                m_acc[k] = 0; m_ovf[k] = 0; m_hold[k] = 0; m_vld[k] = 0; m_rdy[k] = 1;
            end
        end
        m_after_rst = rst;
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("d%0d in_ready", k), longint'(act_rdy[k]), longint'(m_rdy[k]));
            chk($sformatf("d%0d out_valid", k), longint'(act_vld[k]), longint'(m_vld[k]));
            if (m_vld[k] || m_after_rst) begin
                chk($sformatf("d%0d out_acc", k), act_acc[k], m_oacc[k]);
                chk($sformatf("d%0d out_ovf", k), longint'(act_ovf[k]), longint'(m_oovf[k]));
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input int a, input int b);
        in_valid = 1'b1;
        in_a = 8'(a);
        in_b = 8'(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic beats(input int a, input int b, input int n);
        for (int i = 0; i < n; i++) beat(a, b);
    endtask

    task automatic pin(input string name, input int k, input longint acc, input bit ovf);
        chk({name, " valid"}, longint'(act_vld[k]), 1);
        chk({name, " acc"}, act_acc[k], acc);
        chk({name, " ovf"}, longint'(act_ovf[k]), longint'(ovf));
        chk({name, " model"}, m_oacc[k], acc);
    endtask

    initial begin
        bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        int v;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", longint'(act_rdy[0]), 0);
        chk("reset out_acc", act_acc[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", longint'(act_rdy[0]), 1);

        // basic dot product
        beat(1, 5); beat(2, 6); beat(3, 7); beat(4, 8);
        pin("basic", 0, 70, 0);
        idle(2);

        // sign extremes, then saturation in the 16-bit accumulator
        beats(-128, -128, 4);
        pin("negneg", 0, 65536, 0);
        pin("negneg16", 1, 32767, 1);
        idle(2);
        beats(-128, 127, 4);
        pin("negpos", 0, -65024, 0);
        pin("negpos16", 1, -32768, 1);
        idle(2);
        beats(127, 127, 3); beat(-128, 127);
        pin("railback16", 1, 16511, 1);
        pin("railback32", 0, 32131, 0);
        idle(2);

        // backpressure: result held, input refused
        out_ready = 1'b0;
        beats(1, 1, 4);
        pin("len1", 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 8'(9); in_b = 8'(9);
            @(negedge clk);
            pin("stall", 0, 4, 0);
            chk("stall in_ready", longint'(act_rdy[0]), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("release in_ready", longint'(act_rdy[0]), 1);
        idle(2);

        // input gaps
        v = 1;
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) begin beat(v, v); v++; end
            else idle(1);
        end
        pin("gaps", 0, 30, 0);
        idle(2);

        // reset mid-vector, then reset while holding
        beats(10, 10, 2);
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        out_ready = 1'b0;
        beats(1, 1, 4);
        pin("after rst", 0, 4, 0);
        rst = 1'b1; @(negedge clk);
        chk("rst in hold valid", longint'(act_vld[0]), 0);
        rst = 1'b0; out_ready = 1'b1;
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? -8'sd128 : 8'sd127) : 8'($urandom);
            in_b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? -8'sd128 : 8'sd127) : 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; out_ready = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fxp_dot_accum.md
# fxp_dot_accum

Upstream producer for the fixed-point requantizer. It consumes a stream of signed NIN-bit operand pairs (activation × weight) and accumulates LEN products into a saturating signed NACC-bit sum. It presents each completed dot product, with a sticky overflow flag, on a valid/ready output port. The output feeds the `in` port of `fxp_scale_shift` directly, so both stages share the NACC = 32 default.

## Interface
- NIN, default 8: operand width, signed two's complement.
- NACC, default 32: accumulator and output width; must be ≥ 2*NIN.
- LEN, default 16: products per dot product; must be ≥ 1.

- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operand pair.
- in_a  in  NIN  signed activation.
- in_b  in  NIN  signed weight.
- out_valid  out  1  completed sum available.
- out_ready  in  1  downstream accepts sum.
- out_acc  out  NACC  signed saturated dot product.
- out_ovf  out  1  the sum saturated at least once during this vector.

## Operation
- Handshake: a beat transfers on a rising edge where valid && ready. The block never drops or duplicates a transferred beat.
- State machine has two states, ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready = 1 and out_valid = 0.
  - On each input beat: compute the product p = in_a*in_b at full 2*NIN signed width, then sign-extend it to NACC+1 bits.
  - Form s = acc + p at NACC+1 bits.
  - If s > 2^(NACC-1)-1, load acc = 2^(NACC-1)-1 and set ovf. If s < -2^(NACC-1), load acc = -2^(NACC-1) and set ovf. Otherwise load acc = s.
  - The beat counter cnt (width $clog2(LEN+1)) increments.
  - On the beat with cnt == LEN-1: store the result in the output register, set cnt = 0, and go to HOLD.
  - Beats with in_valid = 0 leave all state unchanged. Gaps of any length are allowed.
- HOLD:
  - in_ready = 0 and out_valid = 1.
  - out_acc and out_ovf hold the completed vector's values and stay stable until transfer.
  - On out_valid && out_ready: clear acc and ovf to 0 and go to ACCUM.
  - No input beat is accepted in the transfer cycle, so there is a minimum one-cycle bubble between vectors.
- Saturation is applied per beat, not once at the end. After clamping, later products of the opposite sign move acc back from the rail. ovf remains set regardless.
- out_ovf is a status flag only. Downstream clipping is the requantizer's job.
- LEN = 1: every accepted beat goes directly to HOLD with acc = the saturated single product.

## Timing
- Reset values: in_ready = 0 while rst is high, then 1 in the first cycle after rst deasserts. out_valid = 0, out_acc = 0, out_ovf = 0. acc = 0, cnt = 0, state = ACCUM.
- Latency: out_valid rises the cycle after the edge that accepts the LEN-th beat. The result is registered, with no combinational path from in_* to out_*.
- Throughput: LEN+1 cycles per vector when both sides are streaming continuously.
- in_ready and out_valid are pure functions of state (registered). Neither depends combinationally on in_valid or out_ready.
- Reset mid-vector or in HOLD: all partial state is discarded, including a pending out_valid. The next vector starts fresh from beat 0.
- rst has priority over any simultaneous handshake on the same edge.

## Test plan
- Basic dot product, LEN=4: a = 1,2,3,4 and b = 5,6,7,8 sent back-to-back -> out_acc = 70, out_ovf = 0. out_valid rises exactly one cycle after the 4th beat.
- Sign extremes, LEN=4: four beats of a = -128, b = -128 -> out_acc = 65536, out_ovf = 0. Then four beats of a = -128, b = 127 -> out_acc = -65024, with acc cleared between the vectors.
- Saturation, NACC=16, LEN=4:
  - Beats (127,127) ×3 then (-128,127) -> out_acc = 32767-16256 = 16511, out_ovf = 1.
  - A separate vector of (-128,127) ×4 -> out_acc = -32768, out_ovf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid rises -> out_acc stays stable and in_ready = 0 throughout, and in_valid = 1 is ignored. Raise out_ready -> transfer happens, and in_ready = 1 the next cycle.
- Input gaps: LEN=4 with in_valid toggling 1,0,0,1,0,1,1 over operands 1×1, 2×2, 3×3, 4×4 -> out_acc = 30 after the 4th accepted beat only.
- Reset mid-vector: accept 2 beats of (10,10), assert rst for 1 cycle, then send 4 beats of (1,1) -> out_acc = 4. Also assert rst while in HOLD -> out_valid drops the next cycle.
